// File: rtl/fnd_port_display_if.sv
// Port bundle between the processor outPort and the FND display driver.
interface fnd_port_display_if;
    logic [7:0] inPort;
    logic [3:0] fndCom;
    logic [7:0] fndFont;
    logic       busy;

    modport master (output inPort, input fndCom, fndFont, busy);
    modport slave  (input inPort, output fndCom, fndFont, busy);
endinterface

// File: rtl/fnd_port_display.sv
// Converts each new 8-bit port value to BCD (sequential double-dabble) and scans it onto a 4-digit FND.
// Define FND_ZERO_BLANK_EN to blank leading-zero digits.
module fnd_port_display #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input logic               clk,
    input logic               reset,
    fnd_port_display_if.slave port_if
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam int unsigned    RW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0]  RMAX = RW'(REFRESH_DIV - 1);

    logic [1:0]    state_q, state_d;
    logic [7:0]    last_q, last_d;
    logic [7:0]    bin_q, bin_d;
    logic [11:0]   bcd_q, bcd_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    hund_q, hund_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    com_q, com_d;
    logic [7:0]    font_q, font_d;
    logic          busy_q, busy_d;
    logic [11:0]   adj;
    logic          lz1, lz2, lz3;

    function automatic logic [7:0] seg(input logic [3:0] v, input logic blank);
        logic [7:0] f;
        if (blank) begin
            f = 8'hFF;
        end else begin
            case (v)
                4'd0:    f = 8'hC0;
                4'd1:    f = 8'hF9;
                4'd2:    f = 8'hA4;
                4'd3:    f = 8'hB0;
                4'd4:    f = 8'h99;
                4'd5:    f = 8'h92;
                4'd6:    f = 8'h82;
                4'd7:    f = 8'hF8;
                4'd8:    f = 8'h80;
                4'd9:    f = 8'h90;
                default: f = 8'hFF;
            endcase
        end
        return f;
    endfunction

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        adj     = bcd_q;
        case (state_q)
            S_IDLE: begin
                if (port_if.inPort != last_q) begin
                    last_d  = port_if.inPort;
                    bin_d   = port_if.inPort;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                // Correct nibbles before the shift so the final shift needs no fix-up.
                for (int unsigned i = 0; i < 3; i++) begin
                    if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
                end
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7) state_d = S_DONE;
            end
            S_DONE: begin
                hund_d  = bcd_q[11:8];
                tens_d  = bcd_q[7:4];
                ones_d  = bcd_q[3:0];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Stays high through the DONE edge so a back-to-back capture keeps it asserted.
        busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
    end

    always_comb begin
        rcnt_d = rcnt_q + 1'b1;
        idx_d  = idx_q;
        if (rcnt_q == RMAX) begin
            rcnt_d = '0;
            idx_d  = idx_q + 2'd1;
        end
`ifdef FND_ZERO_BLANK_EN
        lz3 = 1'b1;
        lz2 = (hund_d == 4'd0);
        lz1 = (hund_d == 4'd0) && (tens_d == 4'd0);
`else
        lz3 = 1'b0;
        lz2 = 1'b0;
        lz1 = 1'b0;
`endif
        com_d = ~(4'b0001 << idx_d);
        case (idx_d)
            2'd0:    font_d = seg(ones_d, 1'b0);
            2'd1:    font_d = seg(tens_d, lz1);
            2'd2:    font_d = seg(hund_d, lz2);
            default: font_d = seg(4'd0, lz3);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            rcnt_q  <= '0;
            idx_q   <= '0;
            com_q   <= 4'b1110;
            font_q  <= 8'hC0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            rcnt_q  <= rcnt_d;
            idx_q   <= idx_d;
            com_q   <= com_d;
            font_q  <= font_d;
            busy_q  <= busy_d;
        end
    end

    assign port_if.fndCom  = com_q;
    assign port_if.fndFont = font_q;
    assign port_if.busy    = busy_q;

endmodule
